// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one external 64-bit ALU between two requesters; owns ZF/SF/OF.
// Define ALU_SHARE_STATS_EN to add saturating grant and conflict counters.
module alu_share_sched #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [1:0]       r0_op,
    input  logic [W-1:0]     r0_a,
    input  logic [W-1:0]     r0_b,
    input  logic             r0_set_cc,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [1:0]       r1_op,
    input  logic [W-1:0]     r1_a,
    input  logic [W-1:0]     r1_b,
    input  logic             r1_set_cc,
    output logic [1:0]       alu_control,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_ans,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    input  logic             rsp_ready,
`ifdef ALU_SHARE_STATS_EN
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     alu_control_q, alu_control_d;
    logic [W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic           set_cc_q, set_cc_d;
    logic           id_q, id_d;
    logic           last_grant_q, last_grant_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           cc_zf_q, cc_zf_d, cc_sf_q, cc_sf_d, cc_of_q, cc_of_d;
    logic           sel;
    logic           xfer;

    always_comb begin
        // On a tie the requester that did not win last time goes next.
        sel      = (r0_valid && r1_valid) ? ~last_grant_q : r1_valid;
        r0_ready = (state_q == IDLE) && r0_valid && !sel;
        r1_ready = (state_q == IDLE) && r1_valid && sel;
        xfer     = r0_ready || r1_ready;

        state_d       = state_q;
        alu_control_d = alu_control_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        set_cc_d      = set_cc_q;
        id_d          = id_q;
        last_grant_d  = last_grant_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        cc_zf_d       = cc_zf_q;
        cc_sf_d       = cc_sf_q;
        cc_of_d       = cc_of_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    alu_control_d = sel ? r1_op     : r0_op;
                    alu_a_d       = sel ? r1_a      : r0_a;
                    alu_b_d       = sel ? r1_b      : r0_b;
                    set_cc_d      = sel ? r1_set_cc : r0_set_cc;
                    id_d          = sel;
                    last_grant_d  = sel;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = alu_ans;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                if (set_cc_q) begin
                    cc_zf_d = (alu_ans == '0);
                    cc_sf_d = alu_ans[W-1];
                    cc_of_d = alu_overflow;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_control_q <= 2'b00;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            set_cc_q      <= 1'b0;
            id_q          <= 1'b0;
            last_grant_q  <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            cc_zf_q       <= 1'b1;
            cc_sf_q       <= 1'b0;
            cc_of_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_control_q <= alu_control_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            set_cc_q      <= set_cc_d;
            id_q          <= id_d;
            last_grant_q  <= last_grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            cc_zf_q       <= cc_zf_d;
            cc_sf_q       <= cc_sf_d;
            cc_of_q       <= cc_of_d;
        end
    end

    assign alu_control = alu_control_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign cc_zf       = cc_zf_q;
    assign cc_sf       = cc_sf_q;
    assign cc_of       = cc_of_q;

`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // All counters stick at all-ones rather than wrapping.
    always_comb begin
        grant_cnt0_d   = grant_cnt0_q;
        grant_cnt1_d   = grant_cnt1_q;
        conflict_cnt_d = conflict_cnt_q;
        if (r0_ready && r0_valid && !(&grant_cnt0_q))
            grant_cnt0_d = grant_cnt0_q + CNT_W'(1);
        if (r1_ready && r1_valid && !(&grant_cnt1_q))
            grant_cnt1_d = grant_cnt1_q + CNT_W'(1);
        if ((state_q == IDLE) && r0_valid && r1_valid && !(&conflict_cnt_q))
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt0_q   <= grant_cnt0_d;
            grant_cnt1_q   <= grant_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched with a behavioural ALU on its alu_* port.
// Build with ALU_SHARE_STATS_EN defined to also check the grant/conflict counters.
module tb_alu_share_sched;

    localparam int W     = 64;
    localparam int CNT_W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           r0_valid, r0_ready, r0_set_cc;
    logic [1:0]     r0_op;
    logic [W-1:0]   r0_a, r0_b;
    logic           r1_valid, r1_ready, r1_set_cc;
    logic [1:0]     r1_op;
    logic [W-1:0]   r1_a, r1_b;
    logic [1:0]     alu_control;
    logic [W-1:0]   alu_a, alu_b, alu_ans;
    logic           alu_overflow;
    logic           rsp_valid, rsp_id, rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           cc_zf, cc_sf, cc_of;
`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

    always #5 clk = ~clk;

    alu_share_sched #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_set_cc(r0_set_cc),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_set_cc(r1_set_cc),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ans(alu_ans), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
`ifdef ALU_SHARE_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt),
`endif
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    // Stand-in for the external execute-stage ALU.
    always_comb begin
        alu_ans      = '0;
        alu_overflow = 1'b0;
        case (alu_control)
            2'b00: begin
                alu_ans      = alu_a + alu_b;
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_ans[W-1] != alu_a[W-1]);
            end
            2'b01: begin
                alu_ans      = alu_a - alu_b;
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_ans[W-1] != alu_a[W-1]);
            end
            2'b10: alu_ans = alu_a & alu_b;
            default: alu_ans = alu_a ^ alu_b;
        endcase
    end

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         zf, sf, of;
    } exp_t;

    exp_t   sb[$];
    logic   grant_log[$];
    int     n_vectors = 0;
    int     n_miscompares = 0;
    int     cyc = 0;
    int     xfer_cyc = 0;
    int     accept_cyc = 0;
    logic   inflight = 1'b0;
    logic   post_reset = 1'b0;
    logic   prev_rsp_valid = 1'b0;
    logic   m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference result using 65-bit sign-extended arithmetic to derive overflow.
    function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] ex;
        logic [W:0] r;
        r = '0;
        case (op)
            2'b00: begin ex = $signed({a[W-1], a}) + $signed({b[W-1], b}); r = {ex[W] ^ ex[W-1], ex[W-1:0]}; end
            2'b01: begin ex = $signed({a[W-1], a}) - $signed({b[W-1], b}); r = {ex[W] ^ ex[W-1], ex[W-1:0]}; end
            2'b10: r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    task automatic record(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic set_cc);
        exp_t e;
        logic [W:0] r;
        r = ref_op(op, a, b);
        if (set_cc) begin
            m_zf = (r[W-1:0] == '0);
            m_sf = r[W-1];
            m_of = r[W];
        end
        e.id = id; e.data = r[W-1:0]; e.zf = m_zf; e.sf = m_sf; e.of = m_of;
        sb.push_back(e);
        grant_log.push_back(id);
        inflight = 1'b1;
        xfer_cyc = cyc;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: records transfers, checks every response against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
            inflight = 1'b0;
            post_reset = 1'b1;
            prev_rsp_valid = 1'b0;
        end else begin
            if (post_reset) begin
                checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                checkOutput("rst_zf", 64'(cc_zf), 64'(1));
                checkOutput("rst_sf", 64'(cc_sf), 64'(0));
                checkOutput("rst_of", 64'(cc_of), 64'(0));
`ifdef ALU_SHARE_STATS_EN
                checkOutput("rst_gcnt0", 64'(grant_cnt0), 64'(0));
                checkOutput("rst_gcnt1", 64'(grant_cnt1), 64'(0));
                checkOutput("rst_conflict", 64'(conflict_cnt), 64'(0));
`endif
                post_reset = 1'b0;
            end
            checkOutput("ready_onehot", 64'(r0_ready & r1_ready), 64'(0));
            if (inflight)
                checkOutput("ready_while_busy", 64'({r0_ready, r1_ready}), 64'(0));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    if (!prev_rsp_valid)
                        checkOutput("rsp_latency", 64'(cyc - xfer_cyc), 64'(2));
                    checkOutput("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    checkOutput("rsp_data", rsp_data, sb[0].data);
                    checkOutput("cc_zf", 64'(cc_zf), 64'(sb[0].zf));
                    checkOutput("cc_sf", 64'(cc_sf), 64'(sb[0].sf));
                    checkOutput("cc_of", 64'(cc_of), 64'(sb[0].of));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        inflight = 1'b0;
                        accept_cyc = cyc;
                    end
                end
            end
            prev_rsp_valid = rsp_valid;
            if (r0_valid && r0_ready)
                record(1'b0, r0_op, r0_a, r0_b, r0_set_cc);
            else if (r1_valid && r1_ready)
                record(1'b1, r1_op, r1_a, r1_b, r1_set_cc);
        end
    end

    task automatic applyStimulus(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic set_cc);
        int   waited;
        logic got;
        waited = 0;
        got = 1'b0;
        if (id == 1'b0) begin
            r0_op = op; r0_a = a; r0_b = b; r0_set_cc = set_cc; r0_valid = 1'b1;
        end else begin
            r1_op = op; r1_a = a; r1_b = b; r1_set_cc = set_cc; r1_valid = 1'b1;
        end
        while (!got && waited < 50) begin
            @(negedge clk);
            if ((id == 1'b0 && r0_ready) || (id == 1'b1 && r1_ready)) got = 1'b1;
            waited++;
        end
        if (!got) checkOutput("grant_timeout", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (id == 1'b0) r0_valid = 1'b0;
        else r1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (inflight && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (inflight) checkOutput("idle_timeout", 64'(inflight), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n, guard, waited;
        logic g0, g1;
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_op = 2'b00; r0_a = '0; r0_b = '0; r0_set_cc = 1'b0;
        r1_valid = 1'b0; r1_op = 2'b00; r1_a = '0; r1_b = '0; r1_set_cc = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_alu_control", 64'(alu_control), 64'(0));
        checkOutput("reset_alu_a", alu_a, 64'(0));
        checkOutput("reset_alu_b", alu_b, 64'(0));
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'(0));
        checkOutput("reset_rsp_data", rsp_data, 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] r0 add 5+7");
        applyStimulus(1'b0, 2'b00, 64'd5, 64'd7, 1'b1);
        wait_idle();

        $display("[TB] r1 sub 3-3 without CC update");
        applyStimulus(1'b1, 2'b01, 64'd3, 64'd3, 1'b0);
        wait_idle();

        $display("[TB] both requesters valid, 6 ops");
        grant_log.delete();
        r0_op = 2'($urandom_range(0, 3)); r0_a = {$urandom, $urandom}; r0_b = {$urandom, $urandom};
        r0_set_cc = 1'($urandom_range(0, 1));
        r1_op = 2'($urandom_range(0, 3)); r1_a = {$urandom, $urandom}; r1_b = {$urandom, $urandom};
        r1_set_cc = 1'($urandom_range(0, 1));
        r0_valid = 1'b1; r1_valid = 1'b1;
        n = 0; guard = 0;
        while (n < 6 && guard < 100) begin
            @(negedge clk);
            g0 = r0_valid && r0_ready;
            g1 = r1_valid && r1_ready;
            @(posedge clk); #1;
            guard++;
            if (g0 || g1) begin
                n++;
                if (g0) begin
                    r0_op = 2'($urandom_range(0, 3)); r0_a = {$urandom, $urandom};
                    r0_b = {$urandom, $urandom}; r0_set_cc = 1'($urandom_range(0, 1));
                end else begin
                    r1_op = 2'($urandom_range(0, 3)); r1_a = {$urandom, $urandom};
                    r1_b = {$urandom, $urandom}; r1_set_cc = 1'($urandom_range(0, 1));
                end
                if (n == 6) begin
                    r0_valid = 1'b0; r1_valid = 1'b0;
                end
            end
        end
        if (n < 6) checkOutput("rr_timeout", 64'(n), 64'(6));
        r0_valid = 1'b0; r1_valid = 1'b0;
        wait_idle();
        checkOutput("rr_count", 64'(grant_log.size()), 64'(6));
        for (int i = 0; i < grant_log.size() && i < 6; i++)
            checkOutput($sformatf("rr_order[%0d]", i), 64'(grant_log[i]), 64'(i % 2));
`ifdef ALU_SHARE_STATS_EN
        checkOutput("grant_cnt0", 64'(grant_cnt0), 64'(4));
        checkOutput("grant_cnt1", 64'(grant_cnt1), 64'(4));
        checkOutput("conflict_cnt", 64'(conflict_cnt), 64'(6));
`endif

        $display("[TB] r0 signed overflow add");
        applyStimulus(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        wait_idle();

        $display("[TB] r0 xor with rsp_ready low, r1 pending");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 2'b11, 64'hFF, 64'h0F, 1'b0);
        r1_op = 2'b00; r1_a = 64'd1; r1_b = 64'd2; r1_set_cc = 1'b0; r1_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!rsp_valid && waited < 20);
        checkOutput("xor_rsp_seen", 64'(rsp_valid), 64'(1));
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!r1_ready && waited < 20);
        checkOutput("next_grant_gap", 64'(cyc - accept_cyc), 64'(1));
        @(posedge clk); #1;
        r1_valid = 1'b0;
        wait_idle();

        $display("[TB] reset during EXEC");
        applyStimulus(1'b1, 2'b10, 64'hFF, 64'hFF, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));

        checkOutput("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
- Shares the single 64-bit execute-stage ALU (add/sub/and/xor, control codes 00/01/10/11) between two requesters:
  - r0: execute-stage OPq path.
  - r1: address/valC computation path.
- Round-robin arbitration, valid/ready request and response handshakes.
- Sequences one ALU operation at a time and owns the Y86-64 condition-code register (ZF/SF/OF).
- Drives an external alu instance through registered control/operand outputs and samples its combinational result.

Parameters:
- W, 64: data width of operands and result; must match the ALU (64).
- CNT_W, 16: width of the optional grant counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 granted; transfer when r0_valid & r0_ready
- r0_op  in  2  ALU control code: 00 add, 01 sub (a-b), 10 and, 11 xor
- r0_a, r0_b  in  W  operands
- r0_set_cc  in  1  update CC from this operation's result
- r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_set_cc: same as r0 for requester 1
- alu_control  out  2  registered to ALU control
- alu_a, alu_b  out  W  registered to ALU operands
- alu_ans  in  W  ALU result (combinational from alu_*)
- alu_overflow  in  1  ALU signed overflow
- rsp_valid  out  1  result available
- rsp_id  out  1  requester that owns the result (0/1)
- rsp_data  out  W  result
- rsp_ready  in  1  consumer accepts result
- cc_zf, cc_sf, cc_of  out  1 each  condition codes

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values:
  - state=IDLE; alu_control=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - last_grant pointer=1, so r0 wins the first tie.
  - Stat counters 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - rN_ready is combinational, asserted only in IDLE, and only for the selected requester.
  - Selection: only one valid → that one; both valid → the one != last_grant.
  - At most one rN_ready high at any time.
  - On transfer: latch op/a/b into alu_control/alu_a/alu_b; latch set_cc and id; set last_grant=id; go to EXEC.
  - No valid: stay in IDLE; alu_* hold their previous values.
- EXEC (exactly 1 cycle):
  - Capture alu_ans → rsp_data, id → rsp_id; set rsp_valid=1.
  - If latched set_cc: ZF=(alu_ans==0), SF=alu_ans[W-1], OF=alu_overflow. OF=0 for op 10/11 comes from the ALU; no extra masking.
  - If set_cc=0: CC unchanged.
  - Go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - No new grant while in RESP.
- Timing:
  - Transfer in cycle T → rsp_valid and CC updates visible at T+2.
  - Earliest next transfer is in the cycle after acceptance; maximum throughput is one op per 3 cycles.
- Boundaries:
  - rsp_ready while rsp_valid=0: ignored.
  - rN_valid dropped before grant: legal, no side effects.
  - Request held valid while the other requester is served: kept pending and granted next IDLE under round-robin, so neither requester starves.
  - Reset in any state: in-flight op discarded, all outputs to reset values the following cycle, no CC update.
  - Arithmetic wraps modulo 2^64 (ALU behaviour); overflow only reflected in OF.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each), reset to 0.
  - Each increments by 1 on a transfer from its requester; saturates at all-ones (no wrap).
  - Adds output conflict_cnt (CNT_W), incremented on each IDLE cycle with both r0_valid and r1_valid high; saturating.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then r0 add a=5, b=7, set_cc=1 with rsp_ready=1 → r0_ready at T, rsp_valid at T+2, rsp_id=0, rsp_data=12, ZF=0, SF=0, OF=0.
- r1 sub a=3, b=3, set_cc=0 after a prior CC state ZF=0 → rsp_data=0, rsp_id=1, CC unchanged (ZF stays 0).
- r0 add a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 → rsp_data=0x8000_0000_0000_0000, SF=1, OF=1, ZF=0.
- Both valid continuously, rsp_ready=1, 6 ops → grant order 0,1,0,1,0,1 with rsp_id matching; with stats enabled, grant_cnt0=3, grant_cnt1=3, conflict_cnt=6.
- rsp_ready=0 for 5 cycles after r0 xor a=0xFF, b=0x0F → rsp_valid and rsp_data=0xF0 held stable; r0_ready/r1_ready stay 0 until one cycle after acceptance.
- rst_n=0 during EXEC of r1 and 0xFF, 0xFF with set_cc=1 → next cycle rsp_valid=0, ZF=1, SF=0, OF=0, no response ever issued.
